i2c_slave: RTL
==============

# i2c_slave

I2C target (responder) with an 8-bit register-pointer protocol, the far-end counterpart of our I2C master's write-byte / read-byte / read-N transactions. It decodes START, address, register pointer, write data and read requests from the synchronised SCL/SDA lines. Register accesses are presented on a simple register-bank port. It sits between the board pins, through the top-level open-drain tristate, and a local register file. The bench uses it as a sensor model against the master; on-chip it exposes FPGA status registers to an external controller.

## Interface
- `SLAVE_ADDR`, default 7'h57: 7-bit address this target answers to.
- `FILT_LEN`, default 4: number of consecutive equal samples required by the glitch filter (only when the filter is compiled in).
- `clk` in, 1: system clock, 50 MHz.
- `rst` in, 1: synchronous, active-high reset.
- `scl_in` in, 1: raw SCL pin. Asynchronous.
- `sda_in` in, 1: raw SDA pin. Asynchronous.
- `sda_out` out, 1: SDA drive value. Constant 0 (open-drain).
- `sda_oe` out, 1: 1 pulls SDA low; 0 releases SDA.
- `reg_addr` out, 8: register pointer.
- `reg_wdata` out, 8: write data.
- `reg_we` out, 1: one-cycle write strobe.
- `reg_re` out, 1: one-cycle read strobe.
- `reg_rdata` in, 8: read data. Must be valid the cycle after `reg_re`.
- `busy` out, 1: high from a START addressed to us until the next STOP, or until the next START addressed elsewhere.
- `start_det` out, 1: one-cycle pulse on every START or repeated START.
- `stop_det` out, 1: one-cycle pulse on every STOP.

## Operation
- Input path:
  - `scl_in` and `sda_in` each pass through a 2-flop synchroniser, then the optional filter, then a registered copy used for edge detection.
  - All decisions use the filtered signals `scl_f` / `sda_f`.
- Bus conditions:
  - START = `sda_f` falls while `scl_f` = 1.
  - STOP = `sda_f` rises while `scl_f` = 1.
  - Both override any state. START goes to ADDR with bit count 0. STOP goes to IDLE.
  - Both release `sda_oe` immediately.
- Sampling and driving:
  - SDA is sampled on the `scl_f` rising edge, MSB first.
  - `sda_oe` changes only on the `scl_f` falling edge.
- States:
  - IDLE: SDA released. Waits for START.
  - ADDR: shifts 8 bits. If `{SLAVE_ADDR, rw}` matches, go to ADDR_ACK and latch `rw`. Otherwise go to IGNORE.
  - ADDR_ACK: drive ACK (`sda_oe` = 1) for the 9th clock. Next state is REG when `rw` = 0, RD when `rw` = 1.
  - On entering RD from ADDR_ACK: `reg_re` pulses with `reg_addr` = pointer. `reg_rdata` is captured into the transmit shifter on the next cycle.
  - REG: 8 bits load the pointer. Then REG_ACK (ACK), then WR.
  - WR: 8 bits, then WR_ACK (ACK). `reg_we` pulses once at the 8th rising edge with `reg_addr` = pointer and `reg_wdata` = byte. The pointer increments at the 9th falling edge. Return to WR.
  - RD: the shifter drives the bit (`sda_oe` = ~bit) on each falling edge. Then RD_ACK releases SDA and samples the master's ACK on the 9th rising edge.
    - ACK (0): pointer++, `reg_re` pulses, back to RD.
    - NACK (1): IGNORE.
  - IGNORE: SDA released. Waits for START or STOP.
- Pointer:
  - 8-bit, wraps 8'hFF→8'h00.
  - Retained across repeated START and STOP, so a write-pointer/restart/read sequence reads from the written pointer.
  - Reset to 0 by `rst`.

## Timing
- Reset values: `sda_out` = 0, `sda_oe` = 0, `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0, `reg_re` = 0, `busy` = 0, `start_det` = 0, `stop_det` = 0. State is IDLE, pointer is 0.
- Pin-to-decision latency:
  - 3 clk without the filter.
  - 3+`FILT_LEN` clk with the filter.
  - Must stay below 1/4 of the SCL low time; at 400 kHz this is satisfied.
- `sda_oe` updates 1 clk after the detected falling edge.
- `reg_re` fires 1 clk after the detected falling edge that ends the ACK bit. `reg_rdata` is captured the following clk, before the first data bit is driven.
- `rst` asserted mid-transaction releases SDA on the next edge and returns to IDLE. The master sees NACK or a released bus.
- START and STOP both detected in one cycle is impossible with a single SDA edge. A STOP arriving during an ACK bit still releases SDA.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined:
  - Each synchronised line updates its filtered value only after `FILT_LEN` consecutive equal samples.
  - Pulses shorter than `FILT_LEN` clk are rejected.
- Undefined: filtered value = synchroniser output, and `FILT_LEN` is unused.

## Test plan
- Write: master write-byte, addr 7'h57, reg 8'h0A, data 8'hC3 -> three ACKs; one `reg_we` with `reg_addr` = 8'h0A, `reg_wdata` = 8'hC3; pointer ends at 8'h0B; `stop_det` pulses.
- Read-one: bank 8'h10 = 8'h5A, master read-byte at reg 8'h10 -> master receives 8'h5A; master NACK; one `reg_re`; `ack_error` = 0.
- Read-N wrap: reg 8'hFE, rd_num = 3, bank = {FE:11, FF:22, 00:33} -> bytes 11, 22, 33; three `reg_re` strobes with addresses FE, FF, 00.
- Wrong address: master targets 7'h3C -> SDA never driven; master `ack_error` = 1; no strobes; `busy` = 0.
- Reset mid-read: assert `rst` during the 4th data bit -> `sda_oe` = 0 within 1 clk; state IDLE; the next full transaction succeeds.
- Filter (macro defined, `FILT_LEN` = 4): 2-clk low glitch on SCL during a high phase -> no extra bit shifted; the write of 8'hC3 is still correct.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target with an 8-bit register pointer driving a simple register-bank port.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a FILT_LEN-sample glitch filter on SCL/SDA.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h57,
  parameter int         FILT_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  state_t     state;
  state_t     state_next;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_s;
  logic       sda_s;
  logic       scl_f;
  logic       sda_f;
  logic       scl_d;
  logic       sda_d;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [3:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] byte_in;
  logic [6:0] tx_shift;
  logic [7:0] ptr;
  logic       rw;
  logic       load_pend;
  logic       tx_load;

  logic cnt_clr;
  logic cnt_inc;
  logic shift_en;
  logic ptr_load;
  logic ptr_inc;
  logic we_set;
  logic re_set;
  logic rw_set;
  logic oe_set;
  logic oe_clr;
  logic tx_shift_en;
  logic busy_set;
  logic busy_clr;

  // Bus lines idle high, so the synchronisers reset to 1 to avoid a false START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [CW-1:0] scl_cnt;
  logic [CW-1:0] sda_cnt;

  // A line only changes once FILT_LEN consecutive samples disagree with the current value.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILT_LEN - 1)) begin
        scl_f   <= scl_s;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILT_LEN - 1)) begin
        sda_f   <= sda_s;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  assign start_cond = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_cond  = scl_f & scl_d & ~sda_d & sda_f;
  assign byte_in    = {shift, sda_f};
  assign tx_load    = load_pend & (state == S_RD);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Data bits count rising edges; bit_cnt==8 waits for the falling edge that opens the ACK slot.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    shift_en    = 1'b0;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;
    we_set      = 1'b0;
    re_set      = 1'b0;
    rw_set      = 1'b0;
    oe_set      = 1'b0;
    oe_clr      = 1'b0;
    tx_shift_en = 1'b0;
    busy_set    = 1'b0;
    busy_clr    = 1'b0;
    if (start_cond) begin
      state_next = S_ADDR;
      cnt_clr    = 1'b1;
      oe_clr     = 1'b1;
    end else if (stop_cond) begin
      state_next = S_IDLE;
      oe_clr     = 1'b1;
      busy_clr   = 1'b1;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            cnt_inc  = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == 4'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw_set   = 1'b1;
                busy_set = 1'b1;
              end else begin
                state_next = S_IGNORE;
                busy_clr   = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_next = S_ADDR_ACK;
            oe_set     = 1'b1;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            oe_clr  = 1'b1;
            cnt_clr = 1'b1;
            if (rw) begin
              state_next = S_RD;
              re_set     = 1'b1;
            end else begin
              state_next = S_REG;
            end
          end
        end
        S_REG: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            cnt_inc  = 1'b1;
            shift_en = 1'b1;
            ptr_load = (bit_cnt == 4'd7);
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_next = S_REG_ACK;
            oe_set     = 1'b1;
          end
        end
        S_REG_ACK: begin
          if (scl_fall) begin
            state_next = S_WR;
            oe_clr     = 1'b1;
            cnt_clr    = 1'b1;
          end
        end
        S_WR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            cnt_inc  = 1'b1;
            shift_en = 1'b1;
            we_set   = (bit_cnt == 4'd7);
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_next = S_WR_ACK;
            oe_set     = 1'b1;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_next = S_WR;
            oe_clr     = 1'b1;
            cnt_clr    = 1'b1;
            ptr_inc    = 1'b1;
          end
        end
        S_RD: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            cnt_inc = 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_next = S_RD_ACK;
              oe_clr     = 1'b1;
            end else begin
              tx_shift_en = 1'b1;
            end
          end
        end
        S_RD_ACK: begin
          // A NACK leaves the state on the rise, so reaching the fall here means ACK.
          if (scl_rise && sda_f) begin
            state_next = S_IGNORE;
          end else if (scl_fall) begin
            state_next = S_RD;
            cnt_clr    = 1'b1;
            ptr_inc    = 1'b1;
            re_set     = 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // reg_rdata is valid the cycle after reg_re, so it is captured two cycles after the strobe decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift     <= 7'd0;
      tx_shift  <= 7'd0;
      ptr       <= 8'd0;
      rw        <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      start_det <= start_cond;
      stop_det  <= stop_cond;
      reg_we    <= we_set;
      reg_re    <= re_set;
      load_pend <= reg_re;
      if (cnt_clr)      bit_cnt <= 4'd0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) shift <= byte_in[6:0];
      if (rw_set)   rw <= sda_f;
      if (ptr_load)     ptr <= byte_in;
      else if (ptr_inc) ptr <= ptr + 8'd1;
      if (we_set) reg_wdata <= byte_in;
      if (busy_clr)      busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;
      if (tx_load)          tx_shift <= reg_rdata[6:0];
      else if (tx_shift_en) tx_shift <= {tx_shift[5:0], 1'b0};
      if (oe_clr)           sda_oe <= 1'b0;
      else if (oe_set)      sda_oe <= 1'b1;
      else if (tx_load)     sda_oe <= ~reg_rdata[7];
      else if (tx_shift_en) sda_oe <= ~tx_shift[6];
    end
  end

  assign sda_out  = 1'b0;
  assign reg_addr = ptr;

endmodule
